load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is clk_i and the reset is rst_i, synchronous and active-high.
REQ-002 Ports SHALL be as follows, listed as name, direction, width, meaning:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- m_valid_i  in  1  memory-stage instruction is a load or store
- m_we_i  in  1  1 = store, 0 = load
- m_size_i  in  2  access size: 00 byte, 01 half, 10 word (11 reserved, treated as word)
- m_unsigned_i  in  1  zero-extend the load result
- m_addr_i  in  32  effective address (the ALU result registered into the memory stage)
- m_store_data_i  in  32  store operand, right-aligned
- m_rd_i  in  5  load destination register
- m_stall_o  out  1  hold the memory stage
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  bus write
- dmem_addr_o  out  32  word address, with [1:0] = 00
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned write data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data
- w_load_valid_o  out  1  load result valid (1-cycle pulse)
- w_load_data_o  out  32  extended load result
- w_rd_o  out  5  load destination register
- misaligned_o  out  1  misaligned access (1-cycle pulse)
- misaligned_addr_o  out  32  faulting address

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-004 In IDLE, an aligned access with m_valid_i=1 SHALL latch addr, we, size, unsigned, store data and rd, then move to REQ.
REQ-005 Alignment SHALL be defined as: half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-006 In IDLE, a misaligned access with m_valid_i=1 SHALL:
- pulse misaligned_o and misaligned_addr_o on the next cycle;
- perform no bus access;
- not stall;
- remain in IDLE.
REQ-007 REQ SHALL behave as follows:
- dmem_req_o=1, with addr, we, be and wdata held stable until dmem_gnt_i=1;
- on grant, a store goes to DONE and a load goes to WAIT.
REQ-008 WAIT SHALL behave as follows:
- dmem_req_o=0;
- on dmem_rvalid_i=1, capture the formatted data and go to DONE.
REQ-009 DONE SHALL behave as follows:
- for a load, pulse w_load_valid_o with w_load_data_o and w_rd_o;
- for a store, w_load_valid_o stays 0;
- return to IDLE unconditionally.
REQ-010 The stall output SHALL be m_stall_o = (IDLE and m_valid_i and aligned) or REQ or WAIT, and SHALL be 0 in DONE, so the pipeline advances exactly once per access.
REQ-011 Store lane alignment SHALL be as follows:
- byte: be = 0001 << addr[1:0], wdata = the byte replicated ×4;
- half: be = 0011 << addr[1:0], wdata = the half replicated ×2;
- word: be = 1111, wdata = the data unchanged.
REQ-012 For loads, dmem_be_o SHALL equal the store-case mask, and dmem_wdata_o SHALL be 0.
REQ-013 Load extraction SHALL be as follows:
- select the byte or half from dmem_rdata_i at addr[1:0];
- sign-extend when m_unsigned_i=0, zero-extend when m_unsigned_i=1;
- pass a word through unchanged.
REQ-014 dmem_rvalid_i outside WAIT SHALL be ignored, including in the cycle of dmem_gnt_i.
REQ-015 dmem_gnt_i outside REQ SHALL be ignored.
REQ-016 Minimum latency, from the accept edge to the end of DONE, SHALL be:
- store with immediate grant: 3 cycles (m_stall_o high for 2);
- load with immediate grant and rvalid on the next cycle: 4 cycles (m_stall_o high for 3).
REQ-017 The request SHALL be fully registered, with no combinational path from m_*_i to dmem_*_o.
REQ-018 There SHALL be no combinational path from dmem_*_i to m_stall_o.

Reset
REQ-019 While rst_i=1 at a rising edge, the state SHALL go to IDLE and every output SHALL be 0; dmem_addr_o, dmem_be_o, dmem_wdata_o, w_load_data_o, w_rd_o and misaligned_addr_o SHALL be 0.
REQ-020 Reset in REQ or WAIT SHALL abandon the access with no w_load_valid_o pulse.
REQ-021 A dmem_rvalid_i arriving after reset SHALL be ignored, per REQ-014.
REQ-022 The first access after reset deasserts SHALL be accepted from IDLE normally.

Verification
REQ-023 Each of the following directed scenarios SHALL be covered by the bench:
- Signed byte load: addr=0x1003, rdata=0x80FF_1234, size=00, unsigned=0 -> be=1000, dmem_addr=0x1000, w_load_data=0xFFFF_FF80, w_rd=m_rd_i, exactly one valid pulse.
- Unsigned half load: addr=0x2002, rdata=0xBEEF_0000, size=01, unsigned=1 -> be=1100, w_load_data=0x0000_BEEF.
- Byte store: addr=0x3001, data=0x0000_00A5, gnt delayed 3 cycles -> req, addr 0x3000, be=0010 and wdata=0xA5A5_A5A5 held 4 cycles, m_stall_o high 4+1 cycles, no w_load_valid_o.
- Misaligned word load: addr=0x4002 -> misaligned_o=1 with addr 0x4002 next cycle, dmem_req_o never asserted, m_stall_o=0.
- Reset in WAIT: then rvalid=1 -> w_load_valid_o stays 0, state IDLE, next load completes correctly.
- Back-to-back: word store then word load with m_valid_i held high -> second access accepted in the cycle after DONE, with no duplicate or dropped access.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Memory-stage request and data-memory bus signals for load_store_unit.
// The slave modport is the LSU; the master modport is the pipeline/memory side.
interface load_store_unit_if;
  logic        m_valid_i;
  logic        m_we_i;
  logic [1:0]  m_size_i;
  logic        m_unsigned_i;
  logic [31:0] m_addr_i;
  logic [31:0] m_store_data_i;
  logic [4:0]  m_rd_i;
  logic        m_stall_o;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  logic        w_load_valid_o;
  logic [31:0] w_load_data_o;
  logic [4:0]  w_rd_o;

  logic        misaligned_o;
  logic [31:0] misaligned_addr_o;

  modport slave (
    input  m_valid_i, m_we_i, m_size_i, m_unsigned_i, m_addr_i, m_store_data_i, m_rd_i,
    output m_stall_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output w_load_valid_o, w_load_data_o, w_rd_o,
    output misaligned_o, misaligned_addr_o
  );

  modport master (
    output m_valid_i, m_we_i, m_size_i, m_unsigned_i, m_addr_i, m_store_data_i, m_rd_i,
    input  m_stall_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  w_load_valid_o, w_load_data_o, w_rd_o,
    input  misaligned_o, misaligned_addr_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores onto byte lanes, extracts and
// extends load data, and flags misaligned accesses without touching the bus.
module load_store_unit (
  input  logic             clk_i,
  input  logic             rst_i,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;

  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [4:0]  rd_q;
  logic [31:0] load_data_q;
  logic        mis_q;
  logic [31:0] mis_addr_q;

  logic        aligned;
  logic        accept;
  logic        misalign_hit;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;

  always_comb begin
    aligned = 1'b1;
    case (lsu.m_size_i)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lsu.m_addr_i[0];
      default: aligned = (lsu.m_addr_i[1:0] == 2'b00);
    endcase
  end

  assign accept       = (state_q == IDLE) && lsu.m_valid_i && aligned;
  assign misalign_hit = (state_q == IDLE) && lsu.m_valid_i && !aligned;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stall depends only on state and m_* inputs, never on the bus responses.
  always_comb begin
    state_d       = state_q;
    lsu.m_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = REQ;
          lsu.m_stall_o = 1'b1;
        end
      end
      REQ: begin
        lsu.m_stall_o = 1'b1;
        if (lsu.dmem_gnt_i) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        lsu.m_stall_o = 1'b1;
        if (lsu.dmem_rvalid_i) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = sdata_q;
    case (size_q)
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = sdata_q;
      end
    endcase
  end

  always_comb begin
    rd_byte  = lsu.dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = lsu.dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    load_fmt = lsu.dmem_rdata_i;
    case (size_q)
      2'b00:   load_fmt = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_fmt = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_fmt = lsu.dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      rd_q        <= '0;
      load_data_q <= '0;
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      mis_q <= misalign_hit;
      if (misalign_hit) mis_addr_q <= lsu.m_addr_i;
      if (accept) begin
        we_q    <= lsu.m_we_i;
        uns_q   <= lsu.m_unsigned_i;
        size_q  <= lsu.m_size_i;
        addr_q  <= lsu.m_addr_i;
        sdata_q <= lsu.m_store_data_i;
        rd_q    <= lsu.m_rd_i;
      end
      if (state_q == WAIT && lsu.dmem_rvalid_i) load_data_q <= load_fmt;
    end
  end

  // Bus fields come only from latched registers and are zero outside REQ.
  assign lsu.dmem_req_o   = (state_q == REQ);
  assign lsu.dmem_we_o    = (state_q == REQ) && we_q;
  assign lsu.dmem_addr_o  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : '0;
  assign lsu.dmem_be_o    = (state_q == REQ) ? lane_be : '0;
  assign lsu.dmem_wdata_o = ((state_q == REQ) && we_q) ? lane_wdata : '0;

  assign lsu.w_load_valid_o = (state_q == DONE) && !we_q;
  assign lsu.w_load_data_o  = load_data_q;
  assign lsu.w_rd_o         = rd_q;

  assign lsu.misaligned_o      = mis_q;
  assign lsu.misaligned_addr_o = mis_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-addressed reference memory predicts
// bus transactions, load results and misaligned faults; a monitor checks them.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .lsu   (bus)
  );

  typedef struct packed {
    bit        we;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
  } bus_t;

  typedef struct packed {
    bit [31:0] data;
    bit [4:0]  rd;
  } wb_t;

  int n_checks = 0;
  int n_fail   = 0;

  bus_t      exp_bus [$];
  wb_t       exp_wb  [$];
  bit [31:0] exp_mis [$];

  bit [7:0]  bmem [bit [31:0]];
  bit [31:0] wmem [bit [29:0]];

  int gnt_delay   = 0;
  int rv_delay    = 0;
  bit force_stray = 1'b0;

  function automatic void check(bit ok, string name, string msg);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, msg);
    end
  endfunction

  function automatic bit [31:0] init_word(bit [29:0] wa);
    return ({wa, 2'b00} * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit [7:0] ref_byte(bit [31:0] a);
    bit [31:0] w;
    if (bmem.exists(a)) return bmem[a];
    w = init_word(a[31:2]);
    return 8'(w >> (8 * a[1:0]));
  endfunction

  function automatic bit [31:0] resp_word(bit [29:0] wa);
    if (wmem.exists(wa)) return wmem[wa];
    return init_word(wa);
  endfunction

  function automatic void preload(bit [31:0] addr, bit [31:0] word);
    wmem[addr[31:2]] = word;
    for (int i = 0; i < 4; i++) bmem[{addr[31:2], 2'b00} + 32'(i)] = 8'(word >> (8 * i));
  endfunction

  function automatic int nbytes(bit [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // Drive one memory-stage instruction, hold it while stalled, retire it.
  task automatic issue(bit we, bit [1:0] size, bit uns, bit [31:0] addr, bit [31:0] data, bit [4:0] rd);
    int                n;
    int                exp_stall;
    int                stalls;
    bus_t              b;
    wb_t               w;
    longint unsigned   v;
    longint unsigned   mask;
    n      = nbytes(size);
    stalls = 0;
    bus.m_valid_i      = 1'b1;
    bus.m_we_i         = we;
    bus.m_size_i       = size;
    bus.m_unsigned_i   = uns;
    bus.m_addr_i       = addr;
    bus.m_store_data_i = data;
    bus.m_rd_i         = rd;
    if ((addr % n) != 0) begin
      exp_mis.push_back(addr);
      exp_stall = 0;
    end else begin
      mask    = (64'd1 << (8 * n)) - 1;
      b.we    = we;
      b.addr  = addr - (addr % 4);
      b.be    = 4'(((1 << n) - 1) << (addr % 4));
      b.wdata = we ? 32'((data & mask) * ((n == 1) ? 32'h0101_0101 : (n == 2) ? 32'h0001_0001 : 32'h1)) : 32'h0;
      exp_bus.push_back(b);
      if (we) begin
        for (int i = 0; i < n; i++) bmem[addr + 32'(i)] = 8'(data >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v |= longint'(ref_byte(addr + 32'(i))) << (8 * i);
        if (!uns && n < 4 && v[8*n-1]) v |= ~mask;
        w.data = 32'(v);
        w.rd   = rd;
        exp_wb.push_back(w);
      end
      exp_stall = 1 + (gnt_delay + 1) + (we ? 0 : rv_delay + 1);
    end
    forever begin
      @(negedge clk);
      if (!bus.m_stall_o) break;
      stalls++;
      if (stalls > 200) begin
        check(1'b0, "stall_timeout", $sformatf("addr=%h still stalled after %0d cycles", addr, stalls));
        break;
      end
      @(posedge clk); #1;
    end
    check(stalls == exp_stall, "stall_cycles",
          $sformatf("addr=%h we=%0b size=%0d got %0d want %0d", addr, we, size, stalls, exp_stall));
    @(posedge clk); #1;
  endtask

  task automatic idle(int cycles);
    bus.m_valid_i      = 1'b0;
    bus.m_we_i         = 1'($urandom);
    bus.m_size_i       = 2'($urandom);
    bus.m_addr_i       = $urandom;
    bus.m_store_data_i = $urandom;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(string name);
    bit any;
    any = bus.m_stall_o | bus.dmem_req_o | bus.dmem_we_o | (|bus.dmem_addr_o) | (|bus.dmem_be_o) |
          (|bus.dmem_wdata_o) | bus.w_load_valid_o | (|bus.w_load_data_o) | (|bus.w_rd_o) |
          bus.misaligned_o | (|bus.misaligned_addr_o);
    check(!any, name, $sformatf("stall=%b req=%b we=%b addr=%h be=%b wdata=%h lv=%b ld=%h rd=%0d mis=%b maddr=%h, want all 0",
          bus.m_stall_o, bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_wdata_o,
          bus.w_load_valid_o, bus.w_load_data_o, bus.w_rd_o, bus.misaligned_o, bus.misaligned_addr_o));
  endtask

  // Memory responder: grants after gnt_delay REQ cycles, returns data rv_delay cycles later.
  bit        r_pending = 1'b0;
  int        r_wcnt    = 0;
  int        r_rcnt    = 0;
  bit [31:0] r_addr    = '0;
  bit [31:0] r_word;

  initial begin
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = '0;
    forever begin
      @(posedge clk); #2;
      bus.dmem_gnt_i    = 1'b0;
      bus.dmem_rvalid_i = 1'b0;
      bus.dmem_rdata_i  = $urandom;
      if (rst) begin
        r_pending = 1'b0;
        r_wcnt    = 0;
        bus.dmem_rvalid_i = force_stray;
      end else if (r_pending) begin
        if (r_rcnt == 0) begin
          bus.dmem_rvalid_i = 1'b1;
          bus.dmem_rdata_i  = resp_word(r_addr[31:2]);
          r_pending         = 1'b0;
        end else begin
          r_rcnt--;
        end
      end else if (bus.dmem_req_o) begin
        if (r_wcnt >= gnt_delay) begin
          bus.dmem_gnt_i = 1'b1;
          r_wcnt         = 0;
          if (bus.dmem_we_o) begin
            r_word = resp_word(bus.dmem_addr_o[31:2]);
            for (int k = 0; k < 4; k++)
              if (bus.dmem_be_o[k]) r_word[8*k +: 8] = bus.dmem_wdata_o[8*k +: 8];
            wmem[bus.dmem_addr_o[31:2]] = r_word;
          end else begin
            r_pending         = 1'b1;
            r_rcnt            = rv_delay;
            r_addr            = bus.dmem_addr_o;
            bus.dmem_rvalid_i = 1'($urandom);
          end
        end else begin
          r_wcnt++;
        end
      end else begin
        bus.dmem_rvalid_i = force_stray || ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a transaction.
  bit   m_hold = 1'b0;
  bus_t m_prev;
  bus_t m_cur;
  bus_t m_eb;
  wb_t  m_ew;
  bit [31:0] m_ea;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_hold = 1'b0;
        continue;
      end
      m_cur = '{bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_wdata_o};
      if (m_hold && bus.dmem_req_o)
        check(m_cur == m_prev, "req_stable", $sformatf("got %h want %h", m_cur, m_prev));
      m_hold = bus.dmem_req_o && !bus.dmem_gnt_i;
      m_prev = m_cur;
      if (bus.dmem_req_o && bus.dmem_gnt_i) begin
        if (exp_bus.size() == 0) begin
          check(1'b0, "bus_unexpected", $sformatf("got we=%0b addr=%h be=%b wdata=%h, want none",
                m_cur.we, m_cur.addr, m_cur.be, m_cur.wdata));
        end else begin
          m_eb = exp_bus.pop_front();
          check(m_cur == m_eb, "bus_txn",
                $sformatf("got we=%0b addr=%h be=%b wdata=%h, want we=%0b addr=%h be=%b wdata=%h",
                m_cur.we, m_cur.addr, m_cur.be, m_cur.wdata, m_eb.we, m_eb.addr, m_eb.be, m_eb.wdata));
        end
      end
      if (bus.w_load_valid_o) begin
        if (exp_wb.size() == 0) begin
          check(1'b0, "load_unexpected", $sformatf("got data=%h rd=%0d, want no pulse", bus.w_load_data_o, bus.w_rd_o));
        end else begin
          m_ew = exp_wb.pop_front();
          check(bus.w_load_data_o == m_ew.data && bus.w_rd_o == m_ew.rd, "load_result",
                $sformatf("got data=%h rd=%0d, want data=%h rd=%0d", bus.w_load_data_o, bus.w_rd_o, m_ew.data, m_ew.rd));
        end
      end
      if (bus.misaligned_o) begin
        if (exp_mis.size() == 0) begin
          check(1'b0, "mis_unexpected", $sformatf("got addr=%h, want no pulse", bus.misaligned_addr_o));
        end else begin
          m_ea = exp_mis.pop_front();
          check(bus.misaligned_addr_o == m_ea, "misaligned_addr",
                $sformatf("got %h want %h", bus.misaligned_addr_o, m_ea));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.m_valid_i      = 1'b0;
    bus.m_we_i         = 1'b0;
    bus.m_size_i       = '0;
    bus.m_unsigned_i   = 1'b0;
    bus.m_addr_i       = '0;
    bus.m_store_data_i = '0;
    bus.m_rd_i         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    // Signed byte load from the top lane.
    preload(32'h1000, 32'h80FF_1234);
    gnt_delay = 0; rv_delay = 0;
    issue(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd7);
    idle(2);

    // Unsigned half load from the upper half.
    preload(32'h2000, 32'hBEEF_0000);
    issue(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 5'd12);
    idle(2);

    // Byte store with a grant delayed by three cycles.
    gnt_delay = 3;
    issue(1'b1, 2'b00, 1'b0, 32'h3001, 32'h0000_00A5, 5'd0);
    gnt_delay = 0;
    idle(3);

    // Misaligned word load never reaches the bus.
    issue(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 5'd3);
    idle(3);

    // Reset while waiting for read data, then a stray rvalid.
    rv_delay = 20;
    bus.m_valid_i    = 1'b1;
    bus.m_we_i       = 1'b0;
    bus.m_size_i     = 2'b10;
    bus.m_unsigned_i = 1'b0;
    bus.m_addr_i     = 32'h5000;
    bus.m_rd_i       = 5'd9;
    exp_bus.push_back('{1'b0, 32'h5000, 4'hF, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check(bus.m_stall_o && !bus.dmem_req_o, "in_wait",
          $sformatf("got stall=%b req=%b want stall=1 req=0", bus.m_stall_o, bus.dmem_req_o));
    rst = 1'b1;
    bus.m_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("reset_in_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    force_stray = 1'b1;
    rv_delay = 0;
    repeat (3) begin
      @(negedge clk);
      check(!bus.w_load_valid_o && !bus.dmem_req_o && !bus.m_stall_o, "stray_rvalid",
            $sformatf("got lv=%b req=%b stall=%b want all 0", bus.w_load_valid_o, bus.dmem_req_o, bus.m_stall_o));
      @(posedge clk); #1;
    end
    force_stray = 1'b0;
    preload(32'h5000, 32'h1357_9BDF);
    issue(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 5'd9);
    idle(2);

    // Back-to-back word store then word load with m_valid held.
    issue(1'b1, 2'b10, 1'b0, 32'h6000, 32'hDEAD_BEEF, 5'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 5'd21);
    idle(2);

    // Random mix over a small window so loads hit earlier stores.
    for (int t = 0; t < 250; t++) begin
      gnt_delay = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      rv_delay  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      issue(1'($urandom), 2'($urandom), 1'($urandom), 32'h100 + $urandom_range(0, 47), $urandom, 5'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(10);
    check(exp_bus.size() == 0 && exp_wb.size() == 0 && exp_mis.size() == 0, "queues_drained",
          $sformatf("got bus=%0d wb=%0d mis=%0d left, want 0", exp_bus.size(), exp_wb.size(), exp_mis.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
